multicycle_ctrl: RTL and testbench

- Multi-cycle control FSM that sequences the shared RV64 datapath: PC, unified memory, IR, register file, ALU, and the PC/imm adders.
- Replaces the single-cycle control unit: one ALU and one memory port are reused across cycles.
- Adds a memory request/ready handshake, an illegal-opcode trap and a retired-instruction counter.
- Sits between the IR opcode field and every datapath write-enable and mux select.

---
 rtl/multicycle_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the shared RV64 datapath.
// Handles the memory handshake, traps illegal opcodes and counts retired instructions.
module multicycle_ctrl #(
  parameter int unsigned CNT_W = 32,
  parameter logic [6:0]  OP_R  = 7'b0110011,
  parameter logic [6:0]  OP_I  = 7'b0010011,
  parameter logic [6:0]  OP_LD = 7'b0000011,
  parameter logic [6:0]  OP_ST = 7'b0100011,
  parameter logic [6:0]  OP_BR = 7'b1100011
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_read,
  output logic             mem_write,
  output logic             iord,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             pc_source,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic             trap,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAddr  = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StExecute  = 4'd6,
    StAluWb    = 4'd7,
    StBranch   = 4'd8,
    StTrap     = 4'd9
  } state_e;

  typedef struct packed {
    logic       mem_req;
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       pc_write_cond;
    logic       pc_source;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_write;
    logic       mem_to_reg;
    logic       trap;
  } ctrl_t;

  // Moore outputs of a state; evaluated on the next state so they can be registered.
  function automatic ctrl_t moore_ctrl(input state_e st, input logic [6:0] op);
    ctrl_t c;
    c = '0;
    case (st)
      StFetch: begin
        c.mem_req   = 1'b1;
        c.mem_read  = 1'b1;
        c.alu_src_b = 2'b01;
      end
      StDecode:  c.alu_src_b = 2'b11;
      StMemAddr: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
      end
      StMemRead: begin
        c.mem_req  = 1'b1;
        c.mem_read = 1'b1;
        c.iord     = 1'b1;
      end
      StMemWb: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      StMemWrite: begin
        c.mem_req   = 1'b1;
        c.mem_write = 1'b1;
        c.iord      = 1'b1;
      end
      StExecute: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = 2'b10;
        c.alu_src_b = (op == OP_I) ? 2'b10 : 2'b00;
      end
      StAluWb:   c.reg_write = 1'b1;
      StBranch: begin
        c.alu_src_a     = 1'b1;
        c.alu_op        = 2'b01;
        c.pc_write_cond = 1'b1;
        c.pc_source     = 1'b1;
      end
      StTrap:    c.trap = 1'b1;
      default:   c = '0;
    endcase
    return c;
  endfunction

  state_e           state_q, state_d;
  ctrl_t            ctrl_q;
  logic [CNT_W-1:0] cnt_q;
  logic             retire;
  logic             legal;
  logic             en;
  logic             fetch_done;

  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    case (state_q)
      StFetch:    if (mem_ready) state_d = StDecode;
      StDecode: begin
        if (opcode == OP_LD || opcode == OP_ST)     state_d = StMemAddr;
        else if (opcode == OP_R || opcode == OP_I)  state_d = StExecute;
        else if (opcode == OP_BR)                   state_d = StBranch;
        else                                        state_d = StTrap;
      end
      StMemAddr:  state_d = (opcode == OP_LD) ? StMemRead : StMemWrite;
      StMemRead:  if (mem_ready) state_d = StMemWb;
      StMemWb: begin
        state_d = StFetch;
        retire  = 1'b1;
      end
      StMemWrite: begin
        if (mem_ready) begin
          state_d = StFetch;
          retire  = 1'b1;
        end
      end
      StExecute:  state_d = StAluWb;
      StAluWb, StBranch: begin
        state_d = StFetch;
        retire  = 1'b1;
      end
      StTrap:     state_d = StTrap;
      default:    state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StFetch;
      ctrl_q  <= moore_ctrl(StFetch, opcode);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= moore_ctrl(state_d, opcode);
      if (retire) cnt_q <= cnt_q + 1'b1;
    end
  end

  // Reset and unreachable encodings force every control output low.
  assign legal      = (state_q <= StTrap);
  assign en         = ~reset & legal;
  assign fetch_done = en & (state_q == StFetch) & mem_ready;

  assign mem_req       = en & ctrl_q.mem_req;
  assign mem_read      = en & ctrl_q.mem_read;
  assign mem_write     = en & ctrl_q.mem_write;
  assign iord          = en & ctrl_q.iord;
  assign ir_write      = fetch_done;
  assign pc_write      = fetch_done;
  assign pc_write_cond = en & ctrl_q.pc_write_cond;
  assign pc_source     = en & ctrl_q.pc_source;
  assign alu_src_a     = en & ctrl_q.alu_src_a;
  assign alu_src_b     = en ? ctrl_q.alu_src_b : 2'b00;
  assign alu_op        = en ? ctrl_q.alu_op : 2'b00;
  assign reg_write     = en & ctrl_q.reg_write;
  assign mem_to_reg    = en & ctrl_q.mem_to_reg;
  assign trap          = en & ctrl_q.trap;
  assign state         = reset ? 4'd0 : state_q;
  assign instr_count   = reset ? '0 : cnt_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: instruction sequencing, wait states, trap,
// counter wrap (4-bit counter) and reset abort.
module tb_multicycle_ctrl;

  localparam int unsigned CW = 4;
  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;

  logic          clk;
  logic          reset;
  logic [6:0]    opcode;
  logic          mem_ready;
  logic          mem_req, mem_read, mem_write, iord, ir_write, pc_write;
  logic          pc_write_cond, pc_source, alu_src_a, reg_write, mem_to_reg, trap;
  logic [1:0]    alu_src_b, alu_op;
  logic [3:0]    state;
  logic [CW-1:0] instr_count;

  int total = 0;
  int bad   = 0;

  multicycle_ctrl #(.CNT_W(CW)) dut (
    .clk          (clk),
    .reset        (reset),
    .opcode       (opcode),
    .mem_ready    (mem_ready),
    .mem_req      (mem_req),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .iord         (iord),
    .ir_write     (ir_write),
    .pc_write     (pc_write),
    .pc_write_cond(pc_write_cond),
    .pc_source    (pc_source),
    .alu_src_a    (alu_src_a),
    .alu_src_b    (alu_src_b),
    .alu_op       (alu_op),
    .reg_write    (reg_write),
    .mem_to_reg   (mem_to_reg),
    .trap         (trap),
    .state        (state),
    .instr_count  (instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One R-type instruction with zero-wait memory, starting and ending in FETCH.
  task automatic run_r();
    opcode    = OP_R;
    mem_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  logic ld_rdy [10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  int   ld_st  [10] = '{0, 0, 0, 1, 2, 3, 3, 3, 3, 4};

  initial begin
    int ir_pulses;
    int rw_seen;
    reset     = 1'b1;
    mem_ready = 1'b1;
    opcode    = 7'd0;
    #1;
    chk("rst_async_mem_req", mem_req, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_mem_req", mem_req, 0);
      chk("rst_ir_write", ir_write, 0);
      chk("rst_state", state, 0);
      chk("rst_count", instr_count, 0);
    end
    reset = 1'b0;
    #1;
    chk("post_rst_state", state, 0);
    chk("post_rst_mem_req", mem_req, 1);
    chk("post_rst_alu_src_b", alu_src_b, 2'b01);
    chk("post_rst_count", instr_count, 0);

    // R-type: 0,1,6,7,0
    opcode = OP_R;
    chk("r_fetch_ir_write", ir_write, 1);
    chk("r_fetch_pc_write", pc_write, 1);
    tick();
    chk("r_decode_state", state, 1);
    chk("r_decode_alu_src_b", alu_src_b, 2'b11);
    chk("r_decode_reg_write", reg_write, 0);
    tick();
    chk("r_exec_state", state, 6);
    chk("r_exec_alu_op", alu_op, 2'b10);
    chk("r_exec_alu_src_b", alu_src_b, 2'b00);
    chk("r_exec_reg_write", reg_write, 0);
    tick();
    chk("r_wb_state", state, 7);
    chk("r_wb_reg_write", reg_write, 1);
    chk("r_wb_count", instr_count, 0);
    tick();
    chk("r_done_state", state, 0);
    chk("r_done_count", instr_count, 1);

    // Load with 2 fetch waits and 3 read waits: 10 cycles to retire.
    opcode    = OP_LD;
    ir_pulses = 0;
    for (int i = 0; i < 10; i++) begin
      mem_ready = ld_rdy[i];
      #1;
      chk("ld_state", state, ld_st[i]);
      if (ir_write) ir_pulses++;
      if (ld_st[i] == 0) chk("ld_fetch_iord", iord, 0);
      if (ld_st[i] == 3) begin
        chk("ld_read_mem_req", mem_req, 1);
        chk("ld_read_iord", iord, 1);
        chk("ld_read_mem_read", mem_read, 1);
      end
      if (ld_st[i] == 4) chk("ld_wb_mem_to_reg", mem_to_reg, 1);
      tick();
    end
    chk("ld_ir_pulses", ir_pulses, 1);
    chk("ld_done_state", state, 0);
    chk("ld_done_count", instr_count, 2);

    // Store: 0,1,2,5 with no register write.
    opcode    = OP_ST;
    mem_ready = 1'b1;
    rw_seen   = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (reg_write) rw_seen++;
      if (i == 3) begin
        chk("st_state", state, 5);
        chk("st_mem_write", mem_write, 1);
        chk("st_mem_read", mem_read, 0);
      end
      tick();
    end
    chk("st_reg_write_seen", rw_seen, 0);
    chk("st_count", instr_count, 3);

    // Branch: 0,1,8.
    opcode = OP_BR;
    tick();
    tick();
    chk("br_state", state, 8);
    chk("br_pc_write_cond", pc_write_cond, 1);
    chk("br_alu_op", alu_op, 2'b01);
    chk("br_pc_source", pc_source, 1);
    tick();
    chk("br_done_state", state, 0);
    chk("br_count", instr_count, 4);

    // Illegal opcode traps and sticks.
    opcode = 7'b1111111;
    tick();
    tick();
    chk("trap_state", state, 9);
    for (int i = 0; i < 20; i++) begin
      mem_ready = logic'(i % 2);
      #1;
      chk("trap_hold", trap, 1);
      chk("trap_no_req", mem_req, 0);
      tick();
    end
    chk("trap_still_state", state, 9);
    reset = 1'b1;
    #1;
    chk("trap_rst_trap", trap, 0);
    tick();
    reset     = 1'b0;
    mem_ready = 1'b1;
    #1;
    chk("trap_rel_state", state, 0);
    chk("trap_rel_trap", trap, 0);
    chk("trap_rel_count", instr_count, 0);

    // Counter wrap with a 4-bit counter.
    for (int i = 0; i < 15; i++) run_r();
    chk("wrap_15", instr_count, 4'hF);
    run_r();
    chk("wrap_0", instr_count, 0);
    run_r();
    chk("wrap_1", instr_count, 1);

    // Reset during a pending read aborts without retiring.
    opcode = OP_LD;
    tick();
    tick();
    tick();
    mem_ready = 1'b0;
    #1;
    chk("abort_state", state, 3);
    chk("abort_mem_req", mem_req, 1);
    reset = 1'b1;
    #1;
    chk("abort_rst_mem_req", mem_req, 0);
    tick();
    reset = 1'b0;
    #1;
    chk("abort_rel_state", state, 0);
    chk("abort_rel_count", instr_count, 0);
    chk("abort_rel_mem_req", mem_req, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
